// File: rtl/rr_bus_responder.sv
// -----------------------------------------------------------------------------
// rr_bus_responder
//   Target-side responder for the two-core shared memory bus. Two initiators
//   (core0, core1) raise a level request with address/rw/data held. The block
//   arbitrates round-robin, runs a fixed-wait-state access on the single
//   RAM/GPIO port and signals completion with a one-cycle grant pulse, with
//   read data valid in that same cycle.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-low reset
//   coreN_request    level request from core N
//   coreN_grant      one-cycle completion pulse to core N
//   coreN_data_in    write data from core N
//   coreN_data_out   read data returned to core N (held until its next read)
//   coreN_address    address from core N
//   coreN_rw         1 = write, 0 = read
//   RAM_address      address to memory (holds its last value when idle)
//   RAM_data_in      write data to memory (holds its last value when idle)
//   RAM_data_out     read data from memory
//   rw               memory write enable, high only during a write access
// -----------------------------------------------------------------------------
module rr_bus_responder #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 9,
  parameter int WAIT_CYCLES    = 2,
  parameter int FIRST_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core0_request,
  output logic              core0_grant,
  input  logic [DATA_W-1:0] core0_data_in,
  output logic [DATA_W-1:0] core0_data_out,
  input  logic [ADDR_W-1:0] core0_address,
  input  logic              core0_rw,
  input  logic              core1_request,
  output logic              core1_grant,
  input  logic [DATA_W-1:0] core1_data_in,
  output logic [DATA_W-1:0] core1_data_out,
  input  logic [ADDR_W-1:0] core1_address,
  input  logic              core1_rw,
  output logic [ADDR_W-1:0] RAM_address,
  output logic [DATA_W-1:0] RAM_data_in,
  input  logic [DATA_W-1:0] RAM_data_out,
  output logic              rw
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  // Counter value of the final ACCESS cycle; read data is captured on its edge.
  localparam logic [3:0] LAST_CNT   = 4'(WAIT_CYCLES - 1);
  localparam logic       FIRST_PRIO = (FIRST_PRIORITY != 0) ? 1'b1 : 1'b0;

  logic [1:0]        state_r;
  logic [3:0]        cnt_r;
  logic              prio_r;     // core that wins when both request
  logic              owner_r;    // core being served
  logic              rw_lat_r;   // latched direction of the current access
  logic [ADDR_W-1:0] ram_addr_r; // latched address, also drives RAM_address
  logic [DATA_W-1:0] ram_wdata_r;
  logic              rw_r;
  logic              grant0_r;
  logic              grant1_r;
  logic [DATA_W-1:0] data0_r;
  logic [DATA_W-1:0] data1_r;

  logic              req_any_s;
  logic              sel_owner_s;
  logic              sel_rw_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;

  // Round-robin selection of the next owner and its transaction fields.
  always_comb begin
    req_any_s   = core0_request | core1_request;
    sel_owner_s = 1'b0;
    if (core0_request && core1_request) begin
      sel_owner_s = prio_r;
    end else if (core1_request) begin
      sel_owner_s = 1'b1;
    end else begin
      sel_owner_s = 1'b0;
    end
    if (sel_owner_s) begin
      sel_rw_s   = core1_rw;
      sel_addr_s = core1_address;
      sel_data_s = core1_data_in;
    end else begin
      sel_rw_s   = core0_rw;
      sel_addr_s = core0_address;
      sel_data_s = core0_data_in;
    end
  end

  // Transaction FSM: IDLE -> ACCESS (WAIT_CYCLES) -> RESP -> GAP -> IDLE.
  // All outputs are registered; rw and the grants are set on the edge that
  // enters the state in which they must be visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      prio_r      <= FIRST_PRIO;
      owner_r     <= 1'b0;
      rw_lat_r    <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= {DATA_W{1'b0}};
      rw_r        <= 1'b0;
      grant0_r    <= 1'b0;
      grant1_r    <= 1'b0;
      data0_r     <= {DATA_W{1'b0}};
      data1_r     <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          grant0_r <= 1'b0;
          grant1_r <= 1'b0;
          if (req_any_s) begin
            owner_r     <= sel_owner_s;
            rw_lat_r    <= sel_rw_s;
            ram_addr_r  <= sel_addr_s;
            ram_wdata_r <= sel_data_s;
            rw_r        <= sel_rw_s;
            cnt_r       <= 4'd0;
            state_r     <= ST_ACCESS;
          end else begin
            rw_r    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == LAST_CNT) begin
            rw_r    <= 1'b0;
            state_r <= ST_RESP;
            if (owner_r) begin
              grant1_r <= 1'b1;
              if (!rw_lat_r) begin
                data1_r <= RAM_data_out;
              end
            end else begin
              grant0_r <= 1'b1;
              if (!rw_lat_r) begin
                data0_r <= RAM_data_out;
              end
            end
          end else begin
            state_r <= ST_ACCESS;
          end
        end
        ST_RESP: begin
          grant0_r <= 1'b0;
          grant1_r <= 1'b0;
          prio_r   <= ~owner_r;
          state_r  <= ST_GAP;
        end
        ST_GAP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          rw_r     <= 1'b0;
          grant0_r <= 1'b0;
          grant1_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign core0_grant    = grant0_r;
  assign core1_grant    = grant1_r;
  assign core0_data_out = data0_r;
  assign core1_data_out = data1_r;
  assign RAM_address    = ram_addr_r;
  assign RAM_data_in    = ram_wdata_r;
  assign rw             = rw_r;

endmodule
